// File: rtl/vec_mem_pkg.sv
// vec_mem_pkg: shared sizes, vector type and scan FSM states for the vector memory scheduler.
package vec_mem_pkg;
    localparam int LANES        = 8;
    localparam int VEC_LANES    = 16;
    localparam int LANE_W       = 16;
    localparam int IMAGE_PIXELS = 96 * 96;

    typedef logic [VEC_LANES-1:0][LANE_W-1:0] vec_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} scan_state_t;

    function automatic vec_t mask_vec(vec_t v);
        vec_t r = '0;
        for (int i = 0; i < LANES; i++) r[i] = v[i];
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter; req[0] wins ties after reset.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_q, last_d;

    always_comb begin
        gnt    = en ? ((req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req) : 2'b00;
        last_d = (gnt == 2'b00) ? last_q : gnt[1];
    end

    always_ff @(posedge clk) last_q <= !rst_n ? 1'b1 : last_d;
endmodule

// File: rtl/vec_mem_scheduler.sv
// vec_mem_scheduler: shares the vector read port between CPU loads and a streaming scan engine,
// with address bounds checks and registered responses.
module vec_mem_scheduler
    import vec_mem_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 96,
    parameter int IMAGE_HEIGHT = 96
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        cpu_req_valid,
    input  logic [15:0] cpu_addr,
    output logic        cpu_req_ready,
    output logic        cpu_rsp_valid,
    output logic        cpu_rsp_err,
    output vec_t        cpu_rsp_data,
    input  logic        scan_start,
    input  logic [15:0] scan_base,
    input  logic [15:0] scan_len,
    output logic        scan_busy,
    output logic        scan_done,
    output logic        scan_err,
    output logic        scan_out_valid,
    input  logic        scan_out_ready,
    output logic [15:0] scan_out_addr,
    output vec_t        scan_out_data,
    output logic [15:0] mem_addr,
    input  vec_t        mem_rd
);
    localparam int PIX = IMAGE_WIDTH * IMAGE_HEIGHT;

    scan_state_t state_q, state_d;
    logic [15:0] cur_q, cur_d, rem_q, rem_d, saddr_q, saddr_d;
    logic        sv_q, sv_d, cv_q, cv_d, cerr_q, cerr_d, done_q, done_d, derr_q, derr_d;
    vec_t        sdata_q, sdata_d, cdata_q, cdata_d;
    logic [1:0]  gnt;
    logic        drain, scan_elig, cpu_ok, scan_bad;

    assign drain     = sv_q && scan_out_ready;
    assign scan_elig = (state_q == RUN) && (rem_q != 16'd0) && (!sv_q || drain);
    assign cpu_ok    = ({1'b0, cpu_addr} + 17'(LANES - 1)) <= 17'(PIX - 1);
    assign scan_bad  = (32'(scan_base) + 32'(scan_len) * 32'(LANES) - 32'd1) > 32'(PIX - 1);

    rr_arbiter2 u_arb (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (RST_N),
        .req   ({scan_elig, cpu_req_valid}),
        .gnt   (gnt)
    );

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        derr_d  = 1'b0;
        if (state_q == IDLE && scan_start) begin
            done_d  = (scan_len == 16'd0) || scan_bad;
            derr_d  = (scan_len != 16'd0) && scan_bad;
            state_d = done_d ? IDLE : RUN;
            cur_d   = scan_base;
            rem_d   = scan_len;
        end
        if (gnt[1]) begin
            cur_d   = cur_q + 16'(LANES);
            rem_d   = rem_q - 16'd1;
            state_d = (rem_q == 16'd1) ? DRAIN : RUN;
        end
        if (state_q == DRAIN && drain) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
        // a fill in the same cycle as a drain simply overwrites the stream register
        sv_d    = gnt[1] ? 1'b1 : (drain ? 1'b0 : sv_q);
        saddr_d = gnt[1] ? cur_q : saddr_q;
        sdata_d = gnt[1] ? mask_vec(mem_rd) : sdata_q;
        cv_d    = gnt[0];
        cerr_d  = gnt[0] && !cpu_ok;
        cdata_d = (gnt[0] && cpu_ok) ? mask_vec(mem_rd) : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            saddr_q <= '0;
            sdata_q <= '0;
            sv_q    <= 1'b0;
            cv_q    <= 1'b0;
            cerr_q  <= 1'b0;
            cdata_q <= '0;
            done_q  <= 1'b0;
            derr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            saddr_q <= saddr_d;
            sdata_q <= sdata_d;
            sv_q    <= sv_d;
            cv_q    <= cv_d;
            cerr_q  <= cerr_d;
            cdata_q <= cdata_d;
            done_q  <= done_d;
            derr_q  <= derr_d;
        end
    end

    assign cpu_req_ready  = gnt[0];
    assign mem_addr       = gnt[0] ? cpu_addr : (gnt[1] ? cur_q : 16'd0);
    assign cpu_rsp_valid  = cv_q;
    assign cpu_rsp_err    = cerr_q;
    assign cpu_rsp_data   = cdata_q;
    assign scan_busy      = state_q != IDLE;
    assign scan_done      = done_q;
    assign scan_err       = derr_q;
    assign scan_out_valid = sv_q;
    assign scan_out_addr  = saddr_q;
    assign scan_out_data  = sdata_q;
endmodule

// File: tb/tb_vec_mem_scheduler.sv
// tb_vec_mem_scheduler: directed checks of CPU loads, bounds, scan streaming, contention and reset.
module tb_vec_mem_scheduler;
    import vec_mem_pkg::*;

    logic        CLK = 1'b0, RST_N = 1'b0;
    logic        cpu_req_valid = 1'b0, scan_start = 1'b0, scan_out_ready = 1'b0;
    logic [15:0] cpu_addr = '0, scan_base = '0, scan_len = '0;
    logic        cpu_req_ready, cpu_rsp_valid, cpu_rsp_err, scan_busy, scan_done, scan_err, scan_out_valid;
    logic [15:0] scan_out_addr, mem_addr;
    vec_t        cpu_rsp_data, scan_out_data, mem_rd;
    int          checks = 0, errors = 0;

    vec_mem_scheduler dut (
        .CLK(CLK), .RST_N(RST_N),
        .cpu_req_valid(cpu_req_valid), .cpu_addr(cpu_addr), .cpu_req_ready(cpu_req_ready),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_err(cpu_rsp_err), .cpu_rsp_data(cpu_rsp_data),
        .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
        .scan_busy(scan_busy), .scan_done(scan_done), .scan_err(scan_err),
        .scan_out_valid(scan_out_valid), .scan_out_ready(scan_out_ready),
        .scan_out_addr(scan_out_addr), .scan_out_data(scan_out_data),
        .mem_addr(mem_addr), .mem_rd(mem_rd)
    );

    always #5 CLK = ~CLK;

    // pixel at address a holds a[7:0]; upper lanes carry junk that must be masked
    always_comb begin
        mem_rd = '0;
        for (int i = 0; i < 16; i++) mem_rd[i] = (i < 8) ? {8'h00, 8'(mem_addr + 16'(i))} : 16'hBEEF;
    end

    function automatic vec_t exp_vec(logic [15:0] a);
        vec_t v = '0;
        for (int i = 0; i < 8; i++) v[i] = {8'h00, 8'(a + 16'(i))};
        return v;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_txn(input logic [15:0] a, input logic e);
        cpu_req_valid = 1'b1;
        cpu_addr = a;
        #1;
        check("cpu_ready", cpu_req_ready, 1);
        check("cpu_mem_addr", mem_addr, a);
        step();
        cpu_req_valid = 1'b0;
        check("cpu_rsp_valid", cpu_rsp_valid, 1);
        check("cpu_rsp_err", cpu_rsp_err, e);
        check("cpu_rsp_data", cpu_rsp_data, e ? '0 : exp_vec(a));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, cpu_rsp_valid, 0);
        check({tag, "_rsp_data"}, cpu_rsp_data, 0);
        check({tag, "_busy"}, scan_busy, 0);
        check({tag, "_done"}, scan_done, 0);
        check({tag, "_sv"}, scan_out_valid, 0);
        check({tag, "_saddr"}, scan_out_addr, 0);
        check({tag, "_sdata"}, scan_out_data, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
    endtask

    initial begin
        step();
        step();
        check_idle_outputs("rst");
        RST_N = 1'b1;
        step();
        check("idle_rsp", cpu_rsp_valid, 0);

        cpu_txn(16'h0010, 1'b0);
        cpu_txn(16'd9208, 1'b0);
        cpu_txn(16'd9209, 1'b1);
        cpu_txn(16'hFFFF, 1'b1);
        step();
        check("cpu_pulse_end", cpu_rsp_valid, 0);

        scan_out_ready = 1'b1;
        scan_base = 16'd0;
        scan_len = 16'd4;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        check("s3_busy0", scan_busy, 1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("s3_valid", scan_out_valid, 1);
            check("s3_addr", scan_out_addr, 16'(k * 8));
            check("s3_data", scan_out_data, exp_vec(16'(k * 8)));
            check("s3_busy", scan_busy, 1);
            check("s3_nodone", scan_done, 0);
        end
        step();
        check("s3_done", scan_done, 1);
        check("s3_err", scan_err, 0);
        check("s3_idle", scan_busy, 0);
        step();
        check("s3_done_pulse", scan_done, 0);

        cpu_req_valid = 1'b1;
        cpu_addr = 16'h0100;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("s4_cpu_ready", cpu_req_ready, (k % 2) == 1);
            step();
        end
        check("s4_done", scan_done, 1);
        check("s4_cpu_rsp", cpu_rsp_valid, 1);
        cpu_req_valid = 1'b0;
        step();

        scan_out_ready = 1'b0;
        scan_base = 16'h0040;
        scan_len = 16'd3;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        step();
        check("s5_first", scan_out_addr, 16'h0040);
        cpu_req_valid = 1'b1;
        cpu_addr = 16'h0200;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("s5_cpu_ready", cpu_req_ready, 1);
            step();
            check("s5_hold_valid", scan_out_valid, 1);
            check("s5_hold_addr", scan_out_addr, 16'h0040);
            check("s5_hold_data", scan_out_data, exp_vec(16'h0040));
            check("s5_cpu_data", cpu_rsp_data, exp_vec(16'h0200));
        end
        cpu_req_valid = 1'b0;
        scan_out_ready = 1'b1;
        step();
        check("s5_addr1", scan_out_addr, 16'h0048);
        step();
        check("s5_addr2", scan_out_addr, 16'h0050);
        check("s5_nodone", scan_done, 0);
        step();
        check("s5_done", scan_done, 1);
        check("s5_err", scan_err, 0);

        scan_base = 16'd9200;
        scan_len = 16'd3;
        scan_start = 1'b1;
        #1;
        check("s6_no_read", mem_addr, 0);
        step();
        scan_start = 1'b0;
        check("s6_rej_done", scan_done, 1);
        check("s6_rej_err", scan_err, 1);
        check("s6_rej_busy", scan_busy, 0);
        check("s6_rej_sv", scan_out_valid, 0);
        scan_len = 16'd0;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        check("s6_len0_done", scan_done, 1);
        check("s6_len0_err", scan_err, 0);
        check("s6_len0_busy", scan_busy, 0);

        scan_base = 16'd0;
        scan_len = 16'd4;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        step();
        check("s6_run", scan_busy, 1);
        RST_N = 1'b0;
        step();
        check_idle_outputs("s6_rst");
        check("s6_rst_ready", cpu_req_ready, 0);
        RST_N = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("s6_no_done", scan_done, 0);
            check("s6_no_busy", scan_busy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_mem_scheduler.md
Name: vec_mem_scheduler

Overview:
- Sequences and shares the single 8-lane vector read port of the image data memory (16 lanes x 16 bit, lanes 0..7 = consecutive 8-bit pixels, lanes 8..15 = 0).
- Two requesters share the port: the CPU vector-load stage (single requests) and an internal scan engine that streams a contiguous run of vectors to the vector pipeline.
- Arbitration is round-robin. The block also performs the address bounds check and registers every response.

Parameters:
IMAGE_WIDTH, 96, image width in pixels
IMAGE_HEIGHT, 96, image height in pixels
LANES, 8, pixels fetched per vector read (address stride of the scan engine)
VEC_LANES, 16, lanes in the response vector
LANE_W, 16, bits per response lane

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  synchronous active-low reset
cpu_req_valid  in  1  CPU vector-load request
cpu_addr  in  16  CPU pixel address
cpu_req_ready  out  1  request accepted this cycle (valid & ready)
cpu_rsp_valid  out  1  one-cycle response pulse, no backpressure
cpu_rsp_err  out  1  response was out of range
cpu_rsp_data  out  VEC_LANES x LANE_W  response vector
scan_start  in  1  start pulse, sampled only when idle
scan_base  in  16  first pixel address of the scan
scan_len  in  16  number of vectors to stream
scan_busy  out  1  scan engine not IDLE
scan_done  out  1  one-cycle pulse at scan completion
scan_err  out  1  valid with scan_done; scan rejected by range check
scan_out_valid  out  1  streamed vector available
scan_out_ready  in  1  consumer accepts streamed vector
scan_out_addr  out  16  base address of the streamed vector
scan_out_data  out  VEC_LANES x LANE_W  streamed vector
mem_addr  out  16  address to data memory (combinational-read port)
mem_rd  in  VEC_LANES x LANE_W  data memory read vector

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, the round-robin pointer favours the CPU, and the response and stream registers are emptied. Reset mid-scan aborts the scan with no scan_done.
- Memory port is combinational. On a grant cycle the block drives mem_addr and captures mem_rd into the winner's output register at the clock edge. Request-to-data latency is 1 cycle.
- Legal address: addr + LANES - 1 <= IMAGE_WIDTH*IMAGE_HEIGHT - 1 (9215 at default), computed at 17 bits with no wrap.
- Illegal CPU address: the request is still accepted, with cpu_rsp_err=1 and cpu_rsp_data all zero.
- Lanes LANES..VEC_LANES-1 of every response are forced to 0.
- CPU eligibility: cpu_req_valid is high. The CPU response has no backpressure.
- Scan eligibility: FSM is RUN, vectors remain to issue, and the stream register is either empty or being drained this cycle (scan_out_valid & scan_out_ready).
- Arbitration: if both requesters are eligible, the one not granted last wins. A single eligible requester always wins.
- cpu_req_ready = CPU is eligible and wins arbitration.
- mem_addr = address of the granted requester; it is 0 when nothing is granted.
- Scan FSM has three states: IDLE, RUN, DRAIN.
- IDLE, on scan_start:
  - If scan_len==0: scan_done=1, scan_err=0 next cycle; stay IDLE.
  - Else if scan_base + scan_len*LANES - 1 exceeds the last pixel (computed at 32 bits): scan_done=1, scan_err=1 next cycle; no reads issued; stay IDLE.
  - Else latch base and count, go to RUN.
- scan_start outside IDLE is ignored.
- RUN: each scan grant issues the vector at cur_addr, then cur_addr += LANES and remaining -= 1. After the last issue, go to DRAIN.
- DRAIN: wait until the final vector has been accepted (scan_out_valid & scan_out_ready). Then pulse scan_done for one cycle (scan_err=0) and return to IDLE.
- scan_busy = 1 in RUN and DRAIN.
- scan_out_valid, scan_out_addr and scan_out_data hold stable until accepted.
- Simultaneous fill and drain of the stream register is allowed: the new data replaces the old and valid stays 1.

Decomposition:
- Shared package vec_mem_pkg holds:
  - LANES, VEC_LANES, LANE_W, IMAGE_PIXELS
  - typedef vec_t (VEC_LANES x LANE_W)
  - scan_state_t enum {IDLE, RUN, DRAIN}
- One sub-module, rr_arbiter2: 2-requester round-robin arbiter with a last-grant pointer and a grant-enable input.
- Bounds check, scan FSM and output registers stay in vec_mem_scheduler.

Test Plan:
1. CPU only: cpu_addr=0x0010, memory holds pixels 0x10..0x17 -> the next cycle shows cpu_rsp_valid=1, err=0, lanes0..7=0x0010..0x0017, lanes8..15=0.
2. CPU bounds: addr=9208 -> err=0, valid data. addr=9209 -> cpu_rsp_err=1 and data all 0. addr=0xFFFF -> err=1 (no wrap).
3. Scan base=0, len=4, scan_out_ready=1 -> scan_out_addr sequence 0, 8, 16, 24 on consecutive cycles, then scan_done one cycle after the last accept; scan_busy high throughout.
4. Contention: CPU valid every cycle during scan len=4 -> grants alternate CPU/scan. The scan finishes in 8 grant cycles, and the CPU sees no two consecutive denials.
5. Backpressure: scan len=3 with scan_out_ready held 0 for 5 cycles -> one vector held stable with no further scan grants; the CPU is still granted. The scan completes after ready rises.
6. Rejects and reset: base=9200, len=3 -> scan_done=1 with scan_err=1, zero reads. len=0 -> done with err=0. RST_N=0 mid-RUN -> all outputs 0 next cycle, no done pulse.
